// File: rtl/mac_seq.sv
// Sequencer feeding a pipelined signed MAC: streams operand pairs, accumulates products, returns dot product + bias.
// Result valid 3 cycles after the last accepted beat; in_ready only in BUSY, DONE holds until result_ready.
module mac_seq #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 32,
    parameter int LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    input  logic [WIDTH-1:0]     bias,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 in_ready,
    output logic                 mac_ce,
    output logic [WIDTH-1:0]     mac_a,
    output logic [WIDTH-1:0]     mac_b,
    output logic [WIDTH-1:0]     mac_c,
    input  logic [2*WIDTH-1:0]   mac_p,
    output logic [ACC_W-1:0]     result,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [LEN_W-1:0]   rem_q;
    logic [WIDTH-1:0]   bias_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [2:0]         tag_q, tag_d;
    logic [2:0]         fst_q, fst_d;
    logic               first_q;
    logic [ACC_W-1:0]   result_q;
    logic               result_valid_q;

    logic               accept;
    logic [ACC_W-1:0]   p_ext;
    logic [ACC_W-1:0]   bias_ext;

    assign in_ready     = (state_q == BUSY) && (rem_q != '0);
    assign accept       = in_valid && in_ready;
    assign mac_ce       = (state_q == BUSY) || (state_q == DRAIN);
    assign mac_a        = accept ? in_a : '0;
    assign mac_b        = accept ? in_b : '0;
    // Bias rides along with element 0 as it enters the MAC adder stage.
    assign mac_c        = (tag_q[1] && fst_q[1]) ? bias_q : '0;
    assign busy         = (state_q != IDLE);
    assign result       = result_q;
    assign result_valid = result_valid_q;

    assign p_ext    = {{(ACC_W-2*WIDTH){mac_p[2*WIDTH-1]}}, mac_p};
    assign bias_ext = {{(ACC_W-WIDTH){bias[WIDTH-1]}}, bias};

    always_comb begin
        acc_d = acc_q;
        tag_d = tag_q;
        fst_d = fst_q;
        if (mac_ce) begin
            tag_d = {tag_q[1:0], accept};
            fst_d = {fst_q[1:0], accept && first_q};
            if (tag_q[2]) begin
                acc_d = acc_q + p_ext;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rem_q          <= '0;
            bias_q         <= '0;
            acc_q          <= '0;
            tag_q          <= '0;
            fst_q          <= '0;
            first_q        <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            tag_q <= tag_d;
            fst_q <= fst_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bias_q         <= bias;
                        tag_q          <= '0;
                        fst_q          <= '0;
                        result_valid_q <= 1'b0;
                        if (len != '0) begin
                            state_q <= BUSY;
                            rem_q   <= len;
                            acc_q   <= '0;
                            first_q <= 1'b1;
                        end else begin
                            // Empty vector: result is the bias alone, valid one edge later.
                            state_q  <= DONE;
                            acc_q    <= bias_ext;
                            result_q <= bias_ext;
                        end
                    end
                end
                BUSY: begin
                    if (accept) begin
                        rem_q   <= rem_q - LEN_W'(1);
                        first_q <= 1'b0;
                        if (rem_q == LEN_W'(1)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // No beats enter in DRAIN, so once the younger tags are clear this edge retires the last product.
                    if (tag_q[1:0] == 2'b00) begin
                        state_q        <= DONE;
                        result_q       <= acc_d;
                        result_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (!result_valid_q) begin
                        result_valid_q <= 1'b1;
                    end else if (result_ready) begin
                        state_q        <= IDLE;
                        result_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq with a behavioural 3-stage signed MAC (no reset, like the real one).
module tb_mac_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic [7:0]  bias;
    logic        in_valid;
    logic [7:0]  in_a, in_b;
    logic        in_ready;
    logic        mac_ce;
    logic [7:0]  mac_a, mac_b, mac_c;
    logic [15:0] mac_p;
    logic [31:0] result;
    logic        result_valid;
    logic        result_ready;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] va [16];
    logic [7:0] vb [16];
    logic       vpat [32];

    // Behavioural MAC: operands registered, multiplied, then c added on the third stage.
    logic signed [7:0]  m_a, m_b;
    logic signed [15:0] m_prod;
    logic signed [15:0] m_p;
    always @(posedge clk) begin
        if (mac_ce) begin
            m_a    <= mac_a;
            m_b    <= mac_b;
            m_prod <= m_a * m_b;
            m_p    <= m_prod + {{8{mac_c[7]}}, mac_c};
        end
    end
    assign mac_p = m_p;

    always #5 clk = ~clk;

    mac_seq #(.WIDTH(8), .ACC_W(32), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .bias(bias),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
        .mac_ce(mac_ce), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_p(mac_p),
        .result(result), .result_valid(result_valid), .result_ready(result_ready),
        .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one command and streams va/vb gated by vpat (valid stays high past the pattern).
    // Returns the number of edges from start to result_valid and side observations.
    task automatic run_cmd(input int n, input logic [7:0] bv, input int npat,
                           output int lat, output logic [31:0] res, output int cnt_c,
                           output logic [7:0] c_val, output int ce_cnt, output int rdy_after,
                           output logic busy0, output logic rdy0);
        int k, idx, p;
        logic acc_now;
        start = 1'b1; len = 8'(n); bias = bv;
        tick();
        start = 1'b0;
        k = 0; idx = 0; p = 0; cnt_c = 0; c_val = 8'h00; ce_cnt = 0; rdy_after = 0;
        busy0 = busy; rdy0 = in_ready;
        while (k < 100 && !result_valid) begin
            in_valid = (p < npat) ? vpat[p] : 1'b1;
            in_a = va[idx]; in_b = vb[idx];
            #1;
            if (mac_ce) ce_cnt++;
            if (mac_c !== 8'h00) begin cnt_c++; c_val = mac_c; end
            if (idx >= n && in_ready) rdy_after++;
            acc_now = in_valid && in_ready;
            tick();
            k++; p++;
            if (acc_now) idx++;
        end
        in_valid = 1'b0;
        lat = k;
        res = result;
    endtask

    task automatic consume();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic clear_pat();
        for (int i = 0; i < 32; i++) vpat[i] = 1'b1;
        for (int i = 0; i < 16; i++) begin va[i] = 8'h00; vb[i] = 8'h00; end
    endtask

    task automatic test_reset();
        n_tests++;
        if ({busy, in_ready, mac_ce, result_valid} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {busy, in_ready, mac_ce, result_valid});
        end
        n_tests++;
        if ({mac_a, mac_b, mac_c} !== 24'h0) begin
            n_fail++; $display("FAIL reset_mac_ops: got %h want 000000", {mac_a, mac_b, mac_c});
        end
        n_tests++;
        if (result !== 32'h0) begin
            n_fail++; $display("FAIL reset_result: got %h want 0", result);
        end
    endtask

    task automatic test_basic();
        int lat, cc, ce, ra; logic [31:0] r; logic [7:0] cv; logic b0, r0;
        clear_pat();
        va[0] = 8'd1; va[1] = 8'd2; va[2] = 8'd3;
        vb[0] = 8'd4; vb[1] = 8'd5; vb[2] = 8'd6;
        run_cmd(3, 8'd10, 0, lat, r, cc, cv, ce, ra, b0, r0);
        n_tests++;
        if ({b0, r0} !== 2'b11) begin n_fail++; $display("FAIL basic_busy_ready: got %b want 11", {b0, r0}); end
        n_tests++;
        if (r !== 32'd42) begin n_fail++; $display("FAIL basic_result: got %0d want 42", $signed(r)); end
        n_tests++;
        if (lat != 6) begin n_fail++; $display("FAIL basic_latency: got %0d want 6", lat); end
        n_tests++;
        if (cc != 1 || cv !== 8'd10) begin n_fail++; $display("FAIL basic_bias_once: got %0d cycles val %0d want 1 cycle val 10", cc, cv); end
        consume();
    endtask

    task automatic test_wide();
        int lat, cc, ce, ra; logic [31:0] r; logic [7:0] cv; logic b0, r0;
        clear_pat();
        for (int i = 0; i < 4; i++) begin va[i] = 8'h80; vb[i] = 8'h80; end
        run_cmd(4, 8'd0, 0, lat, r, cc, cv, ce, ra, b0, r0);
        n_tests++;
        if (r !== 32'd65536) begin n_fail++; $display("FAIL wide_growth: got %0d want 65536", $signed(r)); end
        n_tests++;
        if (lat != 7) begin n_fail++; $display("FAIL wide_latency: got %0d want 7", lat); end
        consume();
        clear_pat();
        va[0] = 8'd127; va[1] = 8'h80;
        vb[0] = 8'h80;  vb[1] = 8'd127;
        run_cmd(2, 8'hFB, 0, lat, r, cc, cv, ce, ra, b0, r0);
        n_tests++;
        if (r !== 32'(-32517)) begin n_fail++; $display("FAIL wide_signed: got %0d want -32517", $signed(r)); end
        consume();
    endtask

    task automatic test_gaps();
        int lat, cc, ce, ra; logic [31:0] r; logic [7:0] cv; logic b0, r0;
        clear_pat();
        va[0] = 8'd1; va[1] = 8'd2; va[2] = 8'd3;
        vb[0] = 8'd4; vb[1] = 8'd5; vb[2] = 8'd6;
        vpat[0] = 1; vpat[1] = 0; vpat[2] = 0; vpat[3] = 1; vpat[4] = 0; vpat[5] = 1;
        run_cmd(3, 8'd10, 6, lat, r, cc, cv, ce, ra, b0, r0);
        n_tests++;
        if (r !== 32'd42) begin n_fail++; $display("FAIL gap_result: got %0d want 42", $signed(r)); end
        n_tests++;
        if (lat != 9) begin n_fail++; $display("FAIL gap_latency: got %0d want 9", lat); end
        n_tests++;
        if (ra != 0) begin n_fail++; $display("FAIL gap_ready_drop: in_ready high %0d cycles after last accept, want 0", ra); end
        n_tests++;
        if (cc != 1) begin n_fail++; $display("FAIL gap_bias_once: got %0d want 1", cc); end
        consume();
    endtask

    task automatic test_zero_len();
        int lat, cc, ce, ra; logic [31:0] r; logic [7:0] cv; logic b0, r0;
        clear_pat();
        run_cmd(0, 8'hF9, 0, lat, r, cc, cv, ce, ra, b0, r0);
        n_tests++;
        if (r !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL zero_result: got %0d want -7", $signed(r)); end
        n_tests++;
        if (lat != 1) begin n_fail++; $display("FAIL zero_latency: got %0d want 1", lat); end
        n_tests++;
        if (ce != 0 || mac_ce !== 1'b0) begin n_fail++; $display("FAIL zero_no_ce: got %0d ce cycles want 0", ce); end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat, cc, ce, ra; logic [31:0] r; logic [7:0] cv; logic b0, r0;
        clear_pat();
        va[0] = 8'd7; vb[0] = 8'hFE;
        run_cmd(1, 8'd20, 0, lat, r, cc, cv, ce, ra, b0, r0);
        n_tests++;
        if (r !== 32'd6) begin n_fail++; $display("FAIL hold_first_result: got %0d want 6", $signed(r)); end
        for (int i = 0; i < 5; i++) begin
            start = (i == 2); len = 8'd5; bias = 8'd1;
            tick();
            start = 1'b0;
            n_tests++;
            if (result !== 32'd6 || result_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_stable[%0d]: got result %0d valid %b busy %b rdy %b want 6 1 1 0",
                         i, $signed(result), result_valid, busy, in_ready);
            end
        end
        consume();
        n_tests++;
        if ({busy, result_valid} !== 2'b00) begin n_fail++; $display("FAIL hold_to_idle: got %b want 00", {busy, result_valid}); end
        clear_pat();
        va[0] = 8'd2; va[1] = 8'hFD;
        vb[0] = 8'd5; vb[1] = 8'd4;
        run_cmd(2, 8'd3, 0, lat, r, cc, cv, ce, ra, b0, r0);
        n_tests++;
        if (r !== 32'd1) begin n_fail++; $display("FAIL b2b_result: got %0d want 1", $signed(r)); end
        n_tests++;
        if (lat != 5) begin n_fail++; $display("FAIL b2b_latency: got %0d want 5", lat); end
        consume();
    endtask

    task automatic test_reset_mid_run();
        int lat, cc, ce, ra; logic [31:0] r; logic [7:0] cv; logic b0, r0;
        start = 1'b1; len = 8'd8; bias = 8'd50;
        in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, in_ready, mac_ce, result_valid} !== 4'b0000 || {mac_a, mac_b, mac_c} !== 24'h0 || result !== 32'h0) begin
            n_fail++;
            $display("FAIL midrun_reset: got busy %b rdy %b ce %b rv %b ops %h res %h want all zero",
                     busy, in_ready, mac_ce, result_valid, {mac_a, mac_b, mac_c}, result);
        end
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        clear_pat();
        va[0] = 8'd3; vb[0] = 8'd3;
        run_cmd(1, 8'd1, 0, lat, r, cc, cv, ce, ra, b0, r0);
        n_tests++;
        if (r !== 32'd10) begin n_fail++; $display("FAIL midrun_fresh_result: got %0d want 10", $signed(r)); end
        n_tests++;
        if (lat != 4) begin n_fail++; $display("FAIL midrun_fresh_latency: got %0d want 4", lat); end
        consume();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; bias = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0; result_ready = 1'b0;
        #12;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_basic();
        test_wide();
        test_gaps();
        test_zero_len();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
